// File: rtl/sport_ram_bist.sv
//-----------------------------------------------------------------------------
// sport_ram_bist
//
// March-test engine for a single-port RAM. On an accepted start it runs three
// phases over every address:
//   1. ascending write of P(a) = PATTERN ^ a
//   2. ascending read/compare of P(a), each followed by a write of Q(a) = ~P(a)
//   3. descending read/compare of Q(a)
// The run stops at the first mismatch and reports the failing address and
// the data that was read back.
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous active-high reset
//   start        single-cycle test request, sampled only in IDLE
//   busy         high while a test is running
//   done         one-cycle pulse when a test finishes
//   pass         result of the last test, held until the next accepted start
//   fail_addr    address of the first mismatch (0 when passing)
//   fail_data    data read at the first mismatch (0 when passing)
//   ram_addr     RAM address
//   ram_wenable  RAM write enable
//   ram_data_in  RAM write data (0 whenever ram_wenable is 0)
//   ram_data_out RAM read data, valid RD_LAT cycles after the address
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module sport_ram_bist #(
    parameter int unsigned       ADDR_W  = 3,
    parameter int unsigned       DATA_W  = 32,
    parameter int unsigned       RD_LAT  = 1,
    parameter logic [DATA_W-1:0] PATTERN = 32'hA5A5_A5A5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wenable,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        W0       = 3'd1,
        R0_ISSUE = 3'd2,
        R0_WAIT  = 3'd3,
        W1       = 3'd4,
        R1_ISSUE = 3'd5,
        R1_WAIT  = 3'd6,
        DONE     = 3'd7
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    // Index of the wait cycle in which read data is valid.
    localparam logic [2:0]        LAST_WAIT = 3'(RD_LAT - 1);

    state_t            state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [2:0]        wait_r;
    logic [ADDR_W-1:0] addr_inc_s;
    logic [ADDR_W-1:0] addr_dec_s;

    // Phase-1/2 expected pattern: base pattern XOR zero-extended address.
    function automatic logic [DATA_W-1:0] pat_p(input logic [ADDR_W-1:0] a);
        return PATTERN ^ {{(DATA_W-ADDR_W){1'b0}}, a};
    endfunction

    // Phase-2/3 expected pattern: complement of pat_p.
    function automatic logic [DATA_W-1:0] pat_q(input logic [ADDR_W-1:0] a);
        return ~pat_p(a);
    endfunction

    // Neighbouring addresses; boundaries are caught before these can wrap.
    assign addr_inc_s = addr_r + ADDR_ONE;
    assign addr_dec_s = addr_r - ADDR_ONE;

    // March-test sequencer; every output is registered and reflects the
    // access performed in the cycle after the edge that sets it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            addr_r      <= ADDR_ZERO;
            wait_r      <= 3'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_addr   <= ADDR_ZERO;
            fail_data   <= DATA_ZERO;
            ram_addr    <= ADDR_ZERO;
            ram_wenable <= 1'b0;
            ram_data_in <= DATA_ZERO;
        end else begin
            // Non-write, non-final cycles are the common case.
            done        <= 1'b0;
            ram_wenable <= 1'b0;
            ram_data_in <= DATA_ZERO;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r     <= W0;
                        addr_r      <= ADDR_ZERO;
                        busy        <= 1'b1;
                        pass        <= 1'b0;
                        fail_addr   <= ADDR_ZERO;
                        fail_data   <= DATA_ZERO;
                        ram_addr    <= ADDR_ZERO;
                        ram_wenable <= 1'b1;
                        ram_data_in <= pat_p(ADDR_ZERO);
                    end else begin
                        ram_addr <= ADDR_ZERO;
                    end
                end
                W0: begin
                    if (addr_r == ADDR_LAST) begin
                        state_r  <= R0_ISSUE;
                        addr_r   <= ADDR_ZERO;
                        ram_addr <= ADDR_ZERO;
                    end else begin
                        addr_r      <= addr_inc_s;
                        ram_addr    <= addr_inc_s;
                        ram_wenable <= 1'b1;
                        ram_data_in <= pat_p(addr_inc_s);
                    end
                end
                R0_ISSUE: begin
                    state_r <= R0_WAIT;
                    wait_r  <= 3'd0;
                end
                R0_WAIT: begin
                    if (wait_r != LAST_WAIT) begin
                        wait_r <= wait_r + 3'd1;
                    end else if (ram_data_out != pat_p(addr_r)) begin
                        state_r   <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= 1'b0;
                        fail_addr <= addr_r;
                        fail_data <= ram_data_out;
                        ram_addr  <= ADDR_ZERO;
                    end else begin
                        state_r     <= W1;
                        ram_wenable <= 1'b1;
                        ram_data_in <= pat_q(addr_r);
                    end
                end
                W1: begin
                    // Phase 3 starts from the top address, already held in addr_r.
                    if (addr_r == ADDR_LAST) begin
                        state_r <= R1_ISSUE;
                    end else begin
                        state_r  <= R0_ISSUE;
                        addr_r   <= addr_inc_s;
                        ram_addr <= addr_inc_s;
                    end
                end
                R1_ISSUE: begin
                    state_r <= R1_WAIT;
                    wait_r  <= 3'd0;
                end
                R1_WAIT: begin
                    if (wait_r != LAST_WAIT) begin
                        wait_r <= wait_r + 3'd1;
                    end else if (ram_data_out != pat_q(addr_r)) begin
                        state_r   <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= 1'b0;
                        fail_addr <= addr_r;
                        fail_data <= ram_data_out;
                        ram_addr  <= ADDR_ZERO;
                    end else if (addr_r == ADDR_ZERO) begin
                        state_r  <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        pass     <= 1'b1;
                        ram_addr <= ADDR_ZERO;
                    end else begin
                        state_r  <= R1_ISSUE;
                        addr_r   <= addr_dec_s;
                        ram_addr <= addr_dec_s;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r  <= IDLE;
                    busy     <= 1'b0;
                    ram_addr <= ADDR_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sport_ram_bist.sv
//-----------------------------------------------------------------------------
// tb_sport_ram_bist
//
// Bench for sport_ram_bist with a behavioural RAM (read latency 1) that can
// inject faults. Expected RAM accesses and run results are queued when a
// test is started and compared as the DUT produces them.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sport_ram_bist;

    localparam int          AW    = 3;
    localparam int          DW    = 32;
    localparam int          DEPTH = 8;
    localparam logic [31:0] PAT   = 32'hA5A5_A5A5;

    typedef struct packed {
        logic        p;
        logic [2:0]  fa;
        logic [31:0] fd;
        logic [7:0]  cyc;
    } res_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
    logic [AW-1:0] ram_addr;
    logic          ram_wenable;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out;

    // RAM model controls: 0 clean, 1 bit0 stuck-at-1 at addr 4, 2 writes to addr 3 lost
    int            fault_mode = 0;
    logic          mem_clear  = 1'b0;
    logic [DW-1:0] mem [DEPTH];

    logic [35:0]   exp_acc[$];
    res_t          exp_res[$];
    logic [31:0]   wr3_log[$];
    int            n_vec    = 0;
    int            n_miss   = 0;
    int            done_cnt = 0;
    int            busy_cnt = 0;
    int            d0;

    always #5 clock = ~clock;

    sport_ram_bist #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .RD_LAT (1),
        .PATTERN(PAT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .fail_addr   (fail_addr),
        .fail_data   (fail_data),
        .ram_addr    (ram_addr),
        .ram_wenable (ram_wenable),
        .ram_data_in (ram_data_in),
        .ram_data_out(ram_data_out)
    );

    // Behavioural single-port RAM, one cycle read latency, with fault injection.
    always @(posedge clock) begin
        ram_data_out <= mem[ram_addr];
        if (mem_clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
        end else if (ram_wenable) begin
            if (fault_mode == 1 && ram_addr == 3'd4) begin
                mem[ram_addr] <= ram_data_in | 32'h1;
            end else if (!(fault_mode == 2 && ram_addr == 3'd3)) begin
                mem[ram_addr] <= ram_data_in;
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pp(input logic [2:0] a);
        return PAT ^ {29'h0, a};
    endfunction

    function automatic logic [31:0] qq(input logic [2:0] a);
        return ~pp(a);
    endfunction

    function automatic res_t mk_res(input logic p, input logic [2:0] fa, input logic [31:0] fd, input int cyc);
        res_t r;
        r.p   = p;
        r.fa  = fa;
        r.fd  = fd;
        r.cyc = 8'(cyc);
        return r;
    endfunction

    // Queue the first 'limit' accesses of a fault-free march and optionally a result.
    task automatic push_run(input int limit, input bit with_res, input res_t r);
        logic [35:0] seq[$];
        for (int a = 0; a < DEPTH; a++) seq.push_back({3'(a), 1'b1, pp(3'(a))});
        for (int a = 0; a < DEPTH; a++) begin
            seq.push_back({3'(a), 1'b0, 32'h0});
            seq.push_back({3'(a), 1'b0, 32'h0});
            seq.push_back({3'(a), 1'b1, qq(3'(a))});
        end
        for (int a = DEPTH - 1; a >= 0; a--) begin
            seq.push_back({3'(a), 1'b0, 32'h0});
            seq.push_back({3'(a), 1'b0, 32'h0});
        end
        for (int i = 0; i < limit && i < seq.size(); i++) exp_acc.push_back(seq[i]);
        if (with_res) exp_res.push_back(r);
    endtask

    task automatic pulse_start();
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c0 = done_cnt;
        int n  = 0;
        while (done_cnt == c0 && n < budget) begin
            @(posedge clock);
            n++;
        end
        check_val("done_timeout", 64'(done_cnt != c0), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check_val(tag, {56'h0, busy, done, pass, fail_addr, ram_addr, ram_wenable}, 64'h0);
        check_val(tag, {fail_data, ram_data_in}, 64'h0);
    endtask

    // Output monitor and scoreboard, sampled on the falling edge.
    initial begin
        res_t r;
        logic [35:0] e;
        forever begin
            @(negedge clock);
            if (reset) begin
                busy_cnt = 0;
                exp_acc.delete();
            end else begin
                if (ram_wenable && ram_addr == 3'd3) wr3_log.push_back(ram_data_in);
                if (busy) begin
                    busy_cnt++;
                    check_val("access_expected", 64'(exp_acc.size() != 0), 64'd1);
                    if (exp_acc.size() != 0) begin
                        e = exp_acc.pop_front();
                        check_val("access", 64'({ram_addr, ram_wenable, ram_data_in}), 64'(e));
                    end
                end else begin
                    check_val("idle_wen", 64'({ram_wenable, ram_data_in}), 64'h0);
                end
                if (done) begin
                    done_cnt++;
                    check_val("result_expected", 64'(exp_res.size() != 0), 64'd1);
                    check_val("access_drained", 64'(exp_acc.size()), 64'd0);
                    if (exp_res.size() != 0) begin
                        r = exp_res.pop_front();
                        check_val("pass", 64'(pass), 64'(r.p));
                        check_val("fail_addr", 64'(fail_addr), 64'(r.fa));
                        check_val("fail_data", 64'(fail_data), 64'(r.fd));
                        check_val("busy_cycles", 64'(busy_cnt), 64'(r.cyc));
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (4) @(posedge clock);
        #1 check_all_zero("reset_idle");

        // Start coincident with reset must be dropped.
        reset = 1'b1;
        start = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1 check_val("start_in_reset", 64'(busy), 64'd0);

        // Clean run: 8 + 8*3 + 8*2 = 48 busy cycles.
        wr3_log.delete();
        push_run(48, 1'b1, mk_res(1'b1, 3'd0, 32'h0, 48));
        pulse_start();
        wait_done(200);
        @(posedge clock);
        #1 check_val("wr3_count", 64'(wr3_log.size()), 64'd2);
        if (wr3_log.size() == 2) begin
            check_val("wr3_first", 64'(wr3_log[0]), 64'hA5A5A5A6);
            check_val("wr3_second", 64'(wr3_log[1]), 64'h5A5A5A59);
        end
        check_val("pass_hold", 64'(pass), 64'd1);

        // Bit0 stuck-at-1 at addr 4: P(4)=A5A5A5A1 already has bit0 set, so
        // phase 2 passes; phase 3 reads Q(4)|1 = 5A5A5A5F after 8+24+8 cycles.
        fault_mode = 1;
        push_run(40, 1'b1, mk_res(1'b0, 3'd4, 32'h5A5A5A5F, 40));
        pulse_start();
        wait_done(200);
        @(posedge clock);
        #1 check_val("fail_hold", 64'(fail_addr), 64'd4);

        // Writes to addr 3 lost, RAM cleared: phase 2 reads 0 at addr 3
        // after 8 + 3*3 + 2 = 19 cycles.
        fault_mode = 2;
        mem_clear  = 1'b1;
        @(posedge clock);
        #1 mem_clear = 1'b0;
        push_run(19, 1'b1, mk_res(1'b0, 3'd3, 32'h0, 19));
        pulse_start();
        wait_done(200);

        // One-cycle reset in phase 2 aborts silently; a fresh start then passes.
        fault_mode = 0;
        push_run(48, 1'b0, mk_res(1'b0, 3'd0, 32'h0, 0));
        pulse_start();
        repeat (20) @(posedge clock);
        #1 reset = 1'b1;
        d0 = done_cnt;
        @(posedge clock);
        #1 reset = 1'b0;
        check_all_zero("abort_outs");
        repeat (5) @(posedge clock);
        #1 check_val("abort_no_done", 64'(done_cnt), 64'(d0));
        push_run(48, 1'b1, mk_res(1'b1, 3'd0, 32'h0, 48));
        pulse_start();
        wait_done(200);

        // Extra start pulses while busy and during the DONE cycle are ignored.
        push_run(48, 1'b1, mk_res(1'b1, 3'd0, 32'h0, 48));
        pulse_start();
        d0 = done_cnt;
        for (int i = 0; i < 150 && done_cnt == d0; i++) begin
            @(posedge clock);
            #1 start = (i % 5 == 0) || done;
        end
        @(posedge clock);
        #1 start = 1'b0;
        check_val("one_done", 64'(done_cnt), 64'(d0 + 1));
        repeat (10) @(posedge clock);
        #1 check_val("no_restart_busy", 64'(busy), 64'd0);
        check_val("no_restart_done", 64'(done_cnt), 64'(d0 + 1));
        check_val("acc_left", 64'(exp_acc.size()), 64'd0);
        check_val("res_left", 64'(exp_res.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
